// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin write port for the register bank, plus a one-register-per-cycle clear sweep.
module regfile_write_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          req_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [ADDR_W-1:0]   addr2_i,
  input  logic [DATA_W-1:0]   data0_i,
  input  logic [DATA_W-1:0]   data1_i,
  input  logic [DATA_W-1:0]   data2_i,
  input  logic                clear_start_i,
  output logic [2:0]          ack_o,
  output logic [NUM_REGS-1:0] reg_enable_o,
  output logic [DATA_W-1:0]   reg_wdata_o,
  output logic                busy_o,
  output logic                clear_done_o
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, c1, c2, win;
  logic [ADDR_W-1:0] cnt_q, cnt_d, waddr;
  logic [2:0] ack_q, ack_d, elig;
  logic [NUM_REGS-1:0] en_q, en_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, wdat;
  logic busy_q, busy_d, done_q, done_d;
  // A source acked this cycle sits out the next edge.
  always_comb begin
    elig = req_i & ~ack_q;
    c1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    win = elig[ptr_q] ? ptr_q : elig[c1] ? c1 : c2;
    waddr = (win == 2'd0) ? addr0_i : (win == 2'd1) ? addr1_i : addr2_i;
    wdat = (win == 2'd0) ? data0_i : (win == 2'd1) ? data1_i : data2_i;
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ack_d = '0;
    en_d = '0;
    wdata_d = wdata_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_q == CLEAR) begin
      busy_d = 1'b1;
      wdata_d = '0;
      if (cnt_q == LAST) begin
        state_d = DONE;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
        en_d = NUM_REGS'(1) << cnt_d;
      end
    end else if (state_q == IDLE && clear_start_i) begin
      state_d = CLEAR;
      cnt_d = '0;
      en_d = NUM_REGS'(1);
      wdata_d = '0;
      busy_d = 1'b1;
    end else begin
      // The DONE cycle already arbitrates, so a held request is acked right after it.
      state_d = IDLE;
      if (|elig) begin
        ack_d = 3'b001 << win;
        en_d = ({1'b0, waddr} < (ADDR_W+1)'(NUM_REGS)) ? NUM_REGS'(1) << waddr : '0;
        wdata_d = wdat;
        ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      ack_q <= '0;
      en_q <= '0;
      wdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      en_q <= en_d;
      wdata_q <= wdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign ack_o = ack_q;
  assign reg_enable_o = en_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o = busy_q;
  assign clear_done_o = done_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random stimulus against a frame-queue reference model.
module tb_regfile_write_arbiter;
  typedef struct packed {
    logic [2:0]  ack;
    logic [15:0] en;
    logic [15:0] wd;
    logic        busy;
    logic        done;
  } frame_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [3:0] addr [3];
  logic [15:0] data [3];
  logic clear_start = 1'b0;
  logic [2:0] ack;
  logic [15:0] en, wd;
  logic busy, done;
  int n_cmp = 0, n_bad = 0;
  bit chk_on = 0;
  frame_t mexp, q[$], got, f;
  int ptr, mw, ms;
  regfile_write_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req),
    .addr0_i(addr[0]), .addr1_i(addr[1]), .addr2_i(addr[2]),
    .data0_i(data[0]), .data1_i(data[1]), .data2_i(data[2]),
    .clear_start_i(clear_start), .ack_o(ack), .reg_enable_o(en),
    .reg_wdata_o(wd), .busy_o(busy), .clear_done_o(done)
  );
  always #5 clk = ~clk;
  // Sweep is a pre-scheduled list of output frames; otherwise arbitrate directly.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      mexp = '0;
      ptr = 0;
    end else if (q.size() != 0) begin
      mexp = q.pop_front();
    end else if (clear_start && !mexp.done) begin
      for (int i = 0; i < 16; i++) begin
        f = '0;
        f.en = 16'(1) << i;
        f.busy = 1'b1;
        q.push_back(f);
      end
      f = '0;
      f.busy = 1'b1;
      f.done = 1'b1;
      q.push_back(f);
      mexp = q.pop_front();
    end else begin
      mw = -1;
      for (int k = 0; k < 3; k++) begin
        ms = (ptr + k) % 3;
        if (mw < 0 && req[ms] && !mexp.ack[ms]) mw = ms;
      end
      mexp.ack = '0;
      mexp.en = '0;
      mexp.busy = 1'b0;
      mexp.done = 1'b0;
      if (mw >= 0) begin
        mexp.ack[mw] = 1'b1;
        mexp.en = 16'(1) << addr[mw];
        mexp.wd = data[mw];
        ptr = (mw + 1) % 3;
      end
    end
  end
  task automatic tick();
    @(negedge clk);
    if (chk_on) begin
      got = {ack, en, wd, busy, done};
      n_cmp++;
      if (got !== mexp) begin
        n_bad++;
        $display("FAIL model t=%0t: got ack=%b en=%h wd=%h busy=%b done=%b want ack=%b en=%h wd=%h busy=%b done=%b",
                 $time, ack, en, wd, busy, done, mexp.ack, mexp.en, mexp.wd, mexp.busy, mexp.done);
      end
    end
  endtask
  task automatic lit(input string nm, input logic [39:0] act, input logic [39:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  bit pend [3];
  int nb;
  bit fin;
  initial begin
    for (int i = 0; i < 3; i++) begin addr[i] = '0; data[i] = '0; end
    tick();
    tick();
    chk_on = 1;
    lit("reset", {ack, en, wd, busy, done}, 40'h0);
    rst_n = 1'b1;
    req = 3'b001; addr[0] = 4'd5; data[0] = 16'hBEEF;
    tick();
    lit("single_ack", ack, 3'b001);
    lit("single_en", en, 16'h0020);
    lit("single_wd", wd, 16'hBEEF);
    req = '0;
    tick();
    lit("single_after", {ack, en}, 40'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin addr[i] = 4'(i + 1); data[i] = 16'(i); end
    req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      tick();
      lit("rr_ack", ack, 3'b001 << (g % 3));
      lit("rr_wd", wd, 40'(g % 3));
    end
    req = '0;
    tick();
    req = 3'b001;
    tick();
    req = '0;
    tick();
    req = 3'b101;
    tick();
    lit("skip_first", ack, 3'b100);
    req = 3'b001;
    tick();
    lit("skip_second", ack, 3'b001);
    req = '0;
    tick();
    clear_start = 1'b1; req = 3'b010; addr[1] = 4'd3; data[1] = 16'h1234;
    tick();
    clear_start = 1'b0;
    nb = 0;
    fin = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      if (busy) begin
        if (nb < 16) lit("sweep_en", {en, wd}, {16'(1) << nb, 16'h0});
        else lit("sweep_done", done, 1);
        nb++;
      end else begin
        lit("post_sweep_ack", ack, 3'b010);
        fin = 1;
      end
      if (!fin) tick();
    end
    lit("sweep_end", fin, 1);
    lit("busy_len", nb, 17);
    req = '0;
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (7) tick();
    lit("step7", en, 16'h0080);
    rst_n = 1'b0;
    tick();
    lit("rst_sweep", {ack, en, wd, busy, done}, 40'h0);
    rst_n = 1'b1; req = 3'b100; addr[2] = 4'd9; data[2] = 16'h5A5A;
    tick();
    lit("post_rst_grant", {ack, en, wd}, {3'b100, 16'h0200, 16'h5A5A});
    req = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; req = 3'b110;
    tick();
    lit("ptr_reset", ack, 3'b010);
    req = 3'b001; rst_n = 1'b0;
    tick();
    lit("rst_grant", {ack, en}, 40'h0);
    rst_n = 1'b1; req = '0;
    tick();
    for (int i = 0; i < 3; i++) pend[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (ack[i]) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          addr[i] = 4'($urandom_range(0, 15));
          data[i] = 16'($urandom);
        end
        req[i] = pend[i];
      end
      clear_start = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
